// File: rtl/bcd_sw_pkg.sv
// Shared types and constants for the M:SS.T stopwatch.
// State encoding, digit moduli, terminal count, width helper.
package bcd_sw_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } sw_state_t;

  localparam int MOD0 = 10;
  localparam int MOD1 = 10;
  localparam int MOD2 = 6;
  localparam int MOD3 = 10;

  localparam logic [15:0] TERM = 16'h9599;

  // Bits needed to count 0..n-1, never less than 1.
  function automatic int clog2(input int n);
    int w;
    for (w = 1; (w < 31) && ((1 << w) < n); w++) begin
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_mod_digit.sv
// One modulo-MOD BCD digit of the count chain.
// Ports: clk, reset (async low), clr, en -> q, tc.
module bcd_mod_digit #(
  parameter int MOD = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       tc
);

  assign tc = (q == 4'(MOD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= tc ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch sequencer: prescaler, digit chain, FSM, lap freeze.
// In: clk, reset, start_stop, clear, lap. Out: disp, running, lap_active, done, tick.
module bcd_stopwatch_ctrl
  import bcd_sw_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int WRAP     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] disp,
  output logic        running,
  output logic        lap_active,
  output logic        done,
  output logic        tick
);

  localparam int PW = clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  sw_state_t     state;
  sw_state_t     state_nx;
  logic [PW-1:0] pre;
  logic [15:0]   live;
  logic [15:0]   snap;
  logic [3:0]    q0, q1, q2, q3;
  logic          tc0, tc1, tc2, tc3;
  logic          at_term;
  logic          hold;
  logic          en0, en1, en2, en3;

  assign tick    = (state == RUN) && (pre == PRE_LAST);
  assign live    = {q3, q2, q1, q0};
  assign at_term = (live == TERM);

  // Without wrap the chain freezes at 9:59.9 instead of rolling.
  assign hold = at_term && (WRAP == 0);

  assign en0 = tick && !hold;
  assign en1 = en0 && tc0;
  assign en2 = en1 && tc1;
  assign en3 = en2 && tc2;

  bcd_mod_digit #(.MOD(MOD0)) u_d0 (
    .clk  (clk),
    .reset(reset),
    .clr  (clear),
    .en   (en0),
    .q    (q0),
    .tc   (tc0)
  );

  bcd_mod_digit #(.MOD(MOD1)) u_d1 (
    .clk  (clk),
    .reset(reset),
    .clr  (clear),
    .en   (en1),
    .q    (q1),
    .tc   (tc1)
  );

  bcd_mod_digit #(.MOD(MOD2)) u_d2 (
    .clk  (clk),
    .reset(reset),
    .clr  (clear),
    .en   (en2),
    .q    (q2),
    .tc   (tc2)
  );

  bcd_mod_digit #(.MOD(MOD3)) u_d3 (
    .clk  (clk),
    .reset(reset),
    .clr  (clear),
    .en   (en3),
    .q    (q3),
    .tc   (tc3)
  );

  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_stop) state_nx = RUN;
        end
        RUN: begin
          if (tick && hold) state_nx = DONE;
          else if (start_stop) state_nx = PAUSE;
        end
        PAUSE: begin
          if (start_stop) state_nx = RUN;
        end
        DONE: begin
          state_nx = DONE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Prescaler only advances in RUN; PAUSE keeps the partial tenth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre <= '0;
    end else if (clear) begin
      pre <= '0;
    end else if (state == RUN) begin
      pre <= tick ? '0 : pre + 1'b1;
    end
  end

  // Snapshot takes the pre-increment count of this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lap_active <= 1'b0;
      snap       <= '0;
    end else if (clear) begin
      lap_active <= 1'b0;
      snap       <= '0;
    end else if (lap) begin
      if (lap_active && (state != IDLE)) begin
        lap_active <= 1'b0;
      end else if ((state == RUN) && !lap_active) begin
        lap_active <= 1'b1;
        snap       <= live;
      end
    end
  end

  assign disp    = lap_active ? snap : live;
  assign running = (state == RUN);
  assign done    = (state == DONE);

  logic unused_tc3;
  assign unused_tc3 = tc3;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Scoreboard bench for bcd_stopwatch_ctrl, TICK_DIV=4.
// Runs WRAP=0 and WRAP=1 instances side by side.
module tb_bcd_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        lap = 1'b0;
  logic [15:0] disp0, disp1;
  logic        running0, running1;
  logic        lap_active0, lap_active1;
  logic        done0, done1;
  logic        tick0, tick1;

  always #5 clk = ~clk;

  bcd_stopwatch_ctrl #(.TICK_DIV(4), .WRAP(0)) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .start_stop(start_stop),
    .clear     (clear),
    .lap       (lap),
    .disp      (disp0),
    .running   (running0),
    .lap_active(lap_active0),
    .done      (done0),
    .tick      (tick0)
  );

  bcd_stopwatch_ctrl #(.TICK_DIV(4), .WRAP(1)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .start_stop(start_stop),
    .clear     (clear),
    .lap       (lap),
    .disp      (disp1),
    .running   (running1),
    .lap_active(lap_active1),
    .done      (done1),
    .tick      (tick1)
  );

  // st: 0 idle, 1 run, 2 pause, 3 done; t: count in tenths
  typedef struct {
    int st;
    int pre;
    int t;
    int snap;
    bit lap;
  } mdl_t;

  typedef struct {
    logic [19:0] e0;
    logic [19:0] e1;
  } exp_t;

  mdl_t m0, m1;
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bcd(input int t);
    int s;
    s = (t / 10) % 60;
    return {4'(t / 600), 4'(s / 10), 4'(s % 10), 4'(t % 10)};
  endfunction

  function automatic mdl_t step(input mdl_t m, input bit ss,
                                input bit cl, input bit lp,
                                input bit wrap);
    mdl_t n;
    bit   tk;
    n  = m;
    tk = (m.st == 1) && (m.pre == 3);
    if (cl) begin
      n.st  = 0;
      n.pre = 0;
      n.t   = 0;
      n.lap = 0;
      n.snap = 0;
      return n;
    end
    if (lp) begin
      if (m.lap && m.st != 0) begin
        n.lap = 0;
      end else if (m.st == 1 && !m.lap) begin
        n.lap  = 1;
        n.snap = m.t;
      end
    end
    if (m.st == 1) n.pre = tk ? 0 : m.pre + 1;
    if (tk) begin
      if (m.t == 5999) begin
        if (wrap) n.t = 0;
      end else begin
        n.t = m.t + 1;
      end
    end
    case (m.st)
      0: if (ss) n.st = 1;
      1: begin
        if (tk && m.t == 5999 && !wrap) n.st = 3;
        else if (ss) n.st = 2;
      end
      2: if (ss) n.st = 1;
      default: ;
    endcase
    return n;
  endfunction

  function automatic logic [19:0] outs(input mdl_t m);
    return {bcd(m.lap ? m.snap : m.t), m.st == 1, m.lap,
            m.st == 3, (m.st == 1) && (m.pre == 3)};
  endfunction

  task automatic cyc(input bit ss, input bit cl, input bit lp);
    exp_t e;
    @(negedge clk);
    start_stop = ss;
    clear      = cl;
    lap        = lp;
    m0 = step(m0, ss, cl, lp, 1'b0);
    m1 = step(m1, ss, cl, lp, 1'b1);
    sb.push_back('{outs(m0), outs(m1)});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("w0 outs", {12'd0, disp0, running0, lap_active0, done0, tick0},
        {12'd0, e.e0});
    chk("w1 outs", {12'd0, disp1, running1, lap_active1, done1, tick1},
        {12'd0, e.e1});
    chk("d2 bcd", 32'(disp0[11:8] <= 4'd5), 32'd1);
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
  endtask

  task automatic run_to(input int t);
    int i;
    for (i = 0; i < 30000; i++) begin
      if (m0.t == t && m0.pre == 0) break;
      cyc(1'b0, 1'b0, 1'b0);
    end
    if (i == 30000) chk("run_to timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int ticks;
    int pt;
    int i;
    m0 = '{default: 0};
    m1 = '{default: 0};
    #1;
    chk("rst outs0", {12'd0, disp0, running0, lap_active0, done0, tick0}, 0);
    chk("rst outs1", {12'd0, disp1, running1, lap_active1, done1, tick1}, 0);
    @(negedge clk);
    reset = 1'b1;

    // start and 40 clocks
    cyc(1'b1, 1'b0, 1'b0);
    ticks = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (tick0) ticks++;
    end
    chk("ticks in 40", 32'(ticks), 32'd10);
    chk("disp 0010", 32'(disp0), 32'h0010);
    chk("running", 32'(running0), 32'd1);

    // lap freeze at 0035, release at 0052
    run_to(35);
    cyc(1'b0, 1'b0, 1'b1);
    chk("lap on", 32'(lap_active0), 32'd1);
    chk("lap disp", 32'(disp0), 32'h0035);
    run_to(52);
    chk("lap frozen", 32'(disp0), 32'h0035);
    cyc(1'b0, 1'b0, 1'b1);
    chk("lap off", 32'(lap_active0), 32'd0);
    chk("lap live", 32'(disp0), 32'h0052);

    // carries
    run_to(99);
    chk("disp 0099", 32'(disp0), 32'h0099);
    run_to(100);
    chk("disp 0100", 32'(disp0), 32'h0100);
    run_to(599);
    chk("disp 0599", 32'(disp0), 32'h0599);
    run_to(600);
    chk("disp 1000", 32'(disp0), 32'h1000);

    // pause with prescaler at 2
    for (i = 0; i < 8; i++) begin
      if (m0.pre == 2) break;
      cyc(1'b0, 1'b0, 1'b0);
    end
    if (i == 8) chk("pre timeout", 32'd0, 32'd1);
    pt = m0.t;
    cyc(1'b1, 1'b0, 1'b0);
    repeat (20) cyc(1'b0, 1'b0, 1'b0);
    chk("pause disp", 32'(disp0), 32'(bcd(pt)));
    chk("pause run", 32'(running0), 32'd0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("resume tick", 32'(tick0), 32'd1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("resume disp", 32'(disp0), 32'(bcd(pt + 1)));
    chk("resume tick2", 32'(tick0), 32'd0);

    // terminal count
    run_to(5999);
    chk("disp 9599", 32'(disp0), 32'h9599);
    for (i = 0; i < 8; i++) begin
      if (m0.st == 3) break;
      cyc(1'b0, 1'b0, 1'b0);
    end
    if (i == 8) chk("done timeout", 32'd0, 32'd1);
    chk("done", 32'(done0), 32'd1);
    chk("done run", 32'(running0), 32'd0);
    chk("done hold", 32'(disp0), 32'h9599);
    chk("wrap disp", 32'(disp1), 32'h0000);
    chk("wrap run", 32'(running1), 32'd1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("done ss", 32'(done0), 32'd1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("clr done", 32'(done0), 32'd0);
    chk("clr disp", 32'(disp0), 32'h0000);

    // async reset mid-count
    cyc(1'b1, 1'b0, 1'b0);
    repeat (9) cyc(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    m0 = '{default: 0};
    m1 = '{default: 0};
    #1;
    chk("arst outs0", {12'd0, disp0, running0, lap_active0, done0, tick0}, 0);
    chk("arst outs1", {12'd0, disp1, running1, lap_active1, done1, tick1}, 0);
    @(negedge clk);
    reset = 1'b1;

    // clear beats start_stop
    cyc(1'b1, 1'b0, 1'b0);
    repeat (6) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("clr+ss run", 32'(running0), 32'd0);
    chk("clr+ss disp", 32'(disp0), 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch_ctrl.md
Name: bcd_stopwatch_ctrl

Overview:
- Sequencer for a 4-digit cascaded BCD count chain forming an M:SS.T stopwatch (tenths, seconds units, seconds tens, minutes).
- Generates the tenth-second tick from the system clock and gates the per-digit enables and carries.
- Runs a start/pause/clear/lap FSM and drives a 16-bit packed BCD value to the display mux.

Parameters:
- TICK_DIV, 100000, clk cycles per tenth-second tick; legal range is 2 or more.
- WRAP, 0, behaviour at 9:59.9. 0 = stop in DONE. 1 = roll over to 0:00.0 and keep running.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. reset=0 clears all state immediately.
- start_stop  in  1  one-cycle command pulse: start, pause or resume.
- clear  in  1  one-cycle command pulse: return to zero and IDLE.
- lap  in  1  one-cycle command pulse: toggle the lap-freeze display.
- disp  out  16  packed BCD. [15:12]=minutes, [11:8]=seconds tens, [7:4]=seconds units, [3:0]=tenths.
- running  out  1  high while in RUN.
- lap_active  out  1  high while disp shows the frozen lap snapshot.
- done  out  1  high while in DONE.
- tick  out  1  one-cycle strobe when the tenths digit is enabled (debug/chaining).

Behaviour:
- Reset (reset=0, async): state=IDLE; prescaler, all digits and the snapshot are 0. disp=16'h0000; running, lap_active, done and tick are 0.
- States and transitions on start_stop:
  - IDLE to RUN.
  - RUN to PAUSE.
  - PAUSE to RUN.
  - DONE: start_stop ignored.
- clear: any state goes to IDLE. Digits, prescaler and lap_active are cleared on the next edge.
- Priority: clear beats start_stop and lap in the same cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN. Holds its value in PAUSE, so a resume continues the partial tenth.
  - tick=1 in the cycle the prescaler equals TICK_DIV-1 and state=RUN. The prescaler wraps to 0 on that edge.
- Digit chain, registered, updated on the edge after tick:
  - d0 (mod 10) is enabled by tick.
  - d1 (mod 10) is enabled by tick & d0==9.
  - d2 (mod 6) is enabled by tick & d0==9 & d1==9.
  - d3 (mod 10) is enabled by tick & d0==9 & d1==9 & d2==5.
  - Each enabled digit at its terminal value returns to 0. Otherwise it increments by 1.
  - Digits never hold non-BCD values (d2 never exceeds 5).
- Terminal count is 9:59.9 (disp=16'h9599) with tick asserted:
  - WRAP=0: digits hold at 9599, state goes to DONE, done=1, running=0. Only clear or reset exits DONE.
  - WRAP=1: all digits go to 0000 and the FSM stays in RUN.
- Lap:
  - In RUN with lap_active=0: lap captures the live count into the snapshot (the value before this edge's increment) and sets lap_active=1. Counting continues.
  - In any non-IDLE state with lap_active=1: lap clears lap_active.
  - Otherwise lap is ignored.
  - disp = lap_active ? snapshot : live digits.
- Entering DONE with lap_active=1 keeps the snapshot; lap releases it.
- Simultaneous tick and start_stop in RUN: the count advances on that edge, then the FSM is in PAUSE.
- Simultaneous tick and lap: the snapshot captures the pre-increment value.
- Latency:
  - Commands take effect on the edge that samples them. running, done and lap_active are registered and valid in the next cycle.
  - disp updates one cycle after tick.

Decomposition:
- Package bcd_sw_pkg holds:
  - state enum {IDLE, RUN, PAUSE, DONE}.
  - Digit modulus constants (10, 10, 6, 10).
  - Terminal constant 16'h9599.
  - Prescaler width function clog2(TICK_DIV).
- Sub-module bcd_mod_digit (parameter MOD), instantiated 4 times:
  - Inputs: clk, reset (async active-low), clr, en.
  - Outputs: q[3:0], tc = (q==MOD-1).
  - q goes to 0 on en & tc.
- The controller holds the FSM, prescaler, carry gating, snapshot register and output mux.

Test Plan:
- TICK_DIV=4, WRAP=0. Pulse start_stop, run 40 clks. Expect tick every 4th clk, disp=16'h0010, running=1.
- Preload the chain by running to 0:09.9, then one more tick. Expect disp=16'h0100. At 0:59.9 plus one tick, expect 16'h1000; d2 never shows 6.
- Run, pulse start_stop when the prescaler is at 2, wait 20 clks. Expect disp unchanged and running=0. Resume; the next tick arrives exactly 1 clk later.
- Run to 16'h0035, pulse lap. Expect lap_active=1 and disp frozen at 0035 while the internal count advances. Pulse lap at internal 0052; expect disp=16'h0052 the next cycle.
- Run to 9:59.9 with WRAP=0. Expect done=1, disp held at 16'h9599, start_stop ignored. Pulse clear; expect IDLE with disp=16'h0000. Repeat with WRAP=1; expect 16'h0000 with running=1.
- Assert reset=0 mid-count asynchronously (between edges). Expect all outputs 0 immediately. Assert clear and start_stop together in RUN; expect IDLE.
